// File: rtl/pkt_read_arbiter_pkg.sv
// Shared constants and types for the packet read arbiter.
// Optional feature macro used by the top: PKT_READ_ARBITER_STAT_EN.
package pkt_read_arbiter_pkg;

    localparam int NUM_PORTS  = 8;
    localparam int PKT_W      = 134;
    localparam int ADDR_W     = 16;
    localparam int RAM_RD_LAT = 2;
    localparam int PORT_W     = 3;
    localparam int CNT_W      = 32;

    typedef logic [PORT_W-1:0] port_idx_t;

    // Tracks which port an in-flight RAM read belongs to.
    typedef struct packed {
        logic      vld;
        port_idx_t idx;
    } tag_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t idx);
        port_onehot      = '0;
        port_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/pkt_read_arbiter_if.sv
// Port-side request/ack bus and RAM read bus of the packet read arbiter.
// slave = arbiter side, master = requesters + RAM side.
interface pkt_read_arbiter_if;

    logic [pkt_read_arbiter_pkg::NUM_PORTS-1:0]          iv_rd_req;
    logic [pkt_read_arbiter_pkg::NUM_PORTS*
           pkt_read_arbiter_pkg::ADDR_W-1:0]             iv_rd_bufadd;
    logic [pkt_read_arbiter_pkg::NUM_PORTS-1:0]          ov_rd_ack;
    logic                                                o_ram_rd;
    logic [pkt_read_arbiter_pkg::ADDR_W-1:0]             ov_ram_rdadd;
    logic [pkt_read_arbiter_pkg::PKT_W-1:0]              iv_ram_rdata;
    logic [pkt_read_arbiter_pkg::PKT_W-1:0]              ov_pkt;
    logic [pkt_read_arbiter_pkg::NUM_PORTS-1:0]          ov_pkt_wr;
    logic [pkt_read_arbiter_pkg::PORT_W-1:0]             ov_arb_state;

    modport slave (
        input  iv_rd_req, iv_rd_bufadd, iv_ram_rdata,
        output ov_rd_ack, o_ram_rd, ov_ram_rdadd, ov_pkt, ov_pkt_wr, ov_arb_state
    );

    modport master (
        output iv_rd_req, iv_rd_bufadd, iv_ram_rdata,
        input  ov_rd_ack, o_ram_rd, ov_ram_rdadd, ov_pkt, ov_pkt_wr, ov_arb_state
    );

endinterface

// File: rtl/pkt_read_arbiter_rr_select.sv
// Round-robin pick among 8 requests, searching from last+1 and wrapping 7->0.
// Latency: combinational. Backpressure: none; caller masks ineligible requests.
module rr_select_8
    import pkt_read_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            last,
    output port_idx_t            gnt_idx,
    output logic                 gnt_vld
);

    port_idx_t cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = last;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = last + port_idx_t'(k);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/pkt_read_arbiter.sv
// Round-robin arbiter turning per-port read requests into central RAM reads (PKT_READ_ARBITER_STAT_EN adds ov_rd_cnt).
// Latency: ack/read 1 cycle after sampled request, ov_pkt_wr 3 cycles after the read.
// Backpressure: none; a port just acked is skipped for one sample so it can drop its request.
module pkt_read_arbiter
    import pkt_read_arbiter_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset,
    pkt_read_arbiter_if.slave   bus
`ifdef PKT_READ_ARBITER_STAT_EN
    ,
    output logic [CNT_W-1:0]    ov_rd_cnt
`endif
);

    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic                 rd_q, rd_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    port_idx_t            ptr_q, ptr_d;
    port_idx_t            state_q, state_d;
    tag_t                 tag_q [RAM_RD_LAT];
    tag_t                 tag_d [RAM_RD_LAT];
    logic [PKT_W-1:0]     pkt_q, pkt_d;
    logic [NUM_PORTS-1:0] pkt_wr_q, pkt_wr_d;

    logic [NUM_PORTS-1:0] elig;
    port_idx_t            sel_idx;
    logic                 sel_vld;

    assign elig = bus.iv_rd_req & ~ack_q;

    rr_select_8 u_rr_select (
        .req     (elig),
        .last    (ptr_q),
        .gnt_idx (sel_idx),
        .gnt_vld (sel_vld)
    );

    always_comb begin
        ack_d   = '0;
        rd_d    = 1'b0;
        addr_d  = '0;
        ptr_d   = ptr_q;
        state_d = state_q;
        if (sel_vld) begin
            ack_d   = port_onehot(sel_idx);
            rd_d    = 1'b1;
            addr_d  = bus.iv_rd_bufadd[int'(sel_idx)*ADDR_W +: ADDR_W];
            ptr_d   = sel_idx;
            state_d = sel_idx;
        end

        // Tag follows the read until its RAM data arrives.
        tag_d[0] = '{vld: rd_q, idx: state_q};
        for (int s = 1; s < RAM_RD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        pkt_d    = '0;
        pkt_wr_d = '0;
        if (tag_q[RAM_RD_LAT-1].vld) begin
            pkt_d    = bus.iv_ram_rdata;
            pkt_wr_d = port_onehot(tag_q[RAM_RD_LAT-1].idx);
        end
    end

    // Pointer resets to 7 so the search after reset starts at port 0.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ack_q    <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            ptr_q    <= port_idx_t'(NUM_PORTS-1);
            state_q  <= '0;
            for (int s = 0; s < RAM_RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
            pkt_q    <= '0;
            pkt_wr_q <= '0;
        end else begin
            ack_q    <= ack_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            ptr_q    <= ptr_d;
            state_q  <= state_d;
            for (int s = 0; s < RAM_RD_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
            pkt_q    <= pkt_d;
            pkt_wr_q <= pkt_wr_d;
        end
    end

    assign bus.ov_rd_ack    = ack_q;
    assign bus.o_ram_rd     = rd_q;
    assign bus.ov_ram_rdadd = addr_q;
    assign bus.ov_arb_state = state_q;
    assign bus.ov_pkt       = pkt_q;
    assign bus.ov_pkt_wr    = pkt_wr_q;

`ifdef PKT_READ_ARBITER_STAT_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {{(CNT_W-1){1'b0}}, rd_q};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign ov_rd_cnt = rd_cnt_q;
`endif

endmodule
